gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYC, default 2, cycles waited after driving a vector before sampling (legal 0..15).
REQ-002 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, begin sweep (sampled in IDLE only).
REQ-005 The block SHALL have port abort, input, 1, terminate sweep and return to IDLE.
REQ-006 The block SHALL have ports a, b, c, d, output, 1 each, stimulus to the NAND/NOR/XOR gate block.
REQ-007 The block SHALL have ports e, f, g, input, 1 each, responses from the gate block.
REQ-008 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse at sweep completion.
REQ-010 The block SHALL have port pass, output, 1, held result: 1 when the last completed sweep had zero mismatches.
REQ-011 The block SHALL have port err_cnt, output, 5, mismatch count, range 0..16.
REQ-012 The block SHALL have ports first_fail, output, 4, index of the first mismatching vector, and fail_valid, output, 1, first_fail is meaningful.

Function
REQ-013 FSM states SHALL be: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-014 IDLE with start=1 and abort=0 SHALL clear idx, err_cnt and fail_valid, and go to DRIVE.
REQ-015 DRIVE SHALL present {a,b,c,d}=idx (a = MSB), load the settle counter with SETTLE_CYC, and go to SETTLE, or to SAMPLE directly when SETTLE_CYC=0.
REQ-016 SETTLE SHALL decrement the settle counter each cycle, hold a..d stable, and go to SAMPLE when the count reaches 1.
REQ-017 SAMPLE SHALL compare {e,f,g} with expected: e=~(a&b), f=~(c|d), g=a^b^c^d.
REQ-018 On a SAMPLE mismatch, err_cnt SHALL increment; if fail_valid=0, first_fail SHALL latch idx and fail_valid SHALL set.
REQ-019 SAMPLE SHALL go to DONE when idx=15; otherwise it SHALL increment idx and go to DRIVE (no wrap beyond 15).
REQ-020 Each vector SHALL take exactly SETTLE_CYC+2 cycles (SETTLE_CYC=0: 2 cycles); a full sweep SHALL take 16*(SETTLE_CYC+2) cycles plus 1 DONE cycle.
REQ-021 DONE SHALL assert done for exactly one cycle, update pass=(err_cnt==0), and return to IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 abort in any non-IDLE state SHALL go to IDLE next cycle, drive a..d=0, produce no done pulse, clear pass, and hold err_cnt, first_fail and fail_valid.
REQ-024 When start and abort are high together in IDLE, abort SHALL win and no sweep starts.
REQ-025 a..d SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_valid=0, idx=0, settle counter=0.
REQ-027 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; after release, the block SHALL await a new start.

Structure
REQ-028 Package gate_sweep_pkg SHALL hold the state enum, N_VEC=16, IDX_W=4, CNT_W=5 and SETTLE_W=4.
REQ-029 Sub-module gate_ref_model SHALL compute the expected {e,f,g} from {a,b,c,d} combinationally; the FSM, counters and result registers SHALL live in gate_sweep_ctrl.

Verification
REQ-030 Correct gate model, SETTLE_CYC=2, start pulse -> busy high; done pulses exactly 65 cycles after start; pass=1, err_cnt=0, fail_valid=0.
REQ-031 Model with g stuck at 0 -> err_cnt=8, first_fail=1, fail_valid=1, pass=0.
REQ-032 SETTLE_CYC=0, correct model -> done 33 cycles after start; a..d sequence 0000..1111, each held 2 cycles.
REQ-033 abort at cycle 20 of a sweep -> IDLE next cycle, busy=0, a..d=0, no done pulse, pass=0; a new start then completes a full sweep with pass=1.
REQ-034 start pulsed again mid-sweep, and start+abort together in IDLE -> sweep length unchanged, and no sweep starts, respectively.
REQ-035 rst asserted at vector 7 between clock edges -> all outputs 0 immediately with no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing for the gate sweep controller.
// Holds the controller state encoding, vector/counter widths and the
// reference truth table for the NAND/NOR/XOR gate block under test.
package gate_sweep_pkg;

    localparam int unsigned N_VEC    = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned RESP_W   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Expected {e,f,g} for stimulus vec = {a,b,c,d} (a is the MSB).
    function automatic logic [RESP_W-1:0] gate_expect(input logic [IDX_W-1:0] vec);
        logic ea;
        logic fa;
        logic ga;
        ea = ~(vec[3] & vec[2]);
        fa = ~(vec[1] | vec[0]);
        ga = ^vec;
        return {ea, fa, ga};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate block: e = NAND(a,b),
// f = NOR(c,d), g = XOR(a,b,c,d).
// Ports:
//   vec        in  [3:0]  stimulus {a,b,c,d}, a = MSB
//   exp_resp_c out [2:0]  expected response {e,f,g}
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  logic [IDX_W-1:0]  vec,
    output logic [RESP_W-1:0] exp_resp_c
);

    always_comb begin
        exp_resp_c = gate_expect(vec);
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep tester for a NAND/NOR/XOR gate block. Drives all 16
// input vectors in order, waits SETTLE_CYC cycles per vector, compares the
// block's response against a reference, and reports mismatch count, first
// failing vector and an overall pass flag.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  begin a sweep (only honoured in IDLE)
//   abort                  abandon a sweep, return to IDLE
//   a, b, c, d             stimulus to the gate block (a = MSB of vector)
//   e, f, g                responses from the gate block
//   busy                   high whenever not in IDLE
//   done                   one-cycle pulse at sweep completion
//   pass                   last completed sweep had no mismatches
//   err_cnt                mismatch count, 0..16
//   first_fail/fail_valid  index of first mismatching vector, valid flag
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2   // legal 0..15
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_fail,
    output logic             fail_valid
);

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [SETTLE_W-1:0]   settle_q;
    logic [SETTLE_W-1:0]   settle_d;
    logic [IDX_W-1:0]      vec_q;
    logic [IDX_W-1:0]      vec_d;
    logic [CNT_W-1:0]      err_d;
    logic [IDX_W-1:0]      first_fail_d;
    logic                  fail_valid_d;
    logic                  pass_d;
    logic                  done_d;
    logic                  busy_d;
    logic [RESP_W-1:0]     exp_resp_c;
    logic                  mismatch_c;

    // Reference response for the vector currently on a..d.
    gate_ref_model u_ref (
        .vec        (vec_q),
        .exp_resp_c (exp_resp_c)
    );

    assign mismatch_c = ({e, f, g} != exp_resp_c);

    assign a = vec_q[3];
    assign b = vec_q[2];
    assign c = vec_q[1];
    assign d = vec_q[0];

    // Next-state and result logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        err_d        = err_cnt;
        first_fail_d = first_fail;
        fail_valid_d = fail_valid;
        pass_d       = pass;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    idx_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                settle_d = SETTLE_W'(SETTLE_CYC);
                state_d  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                // Counter starts at SETTLE_CYC, so SETTLE lasts SETTLE_CYC cycles.
                if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
                if (settle_q <= SETTLE_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_d = err_cnt + CNT_W'(1);
                    if (!fail_valid) begin
                        first_fail_d = idx_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (idx_q == IDX_W'(N_VEC - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_cnt == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the active state wanted, including the
        // result of a SAMPLE in the same cycle; results are held as-is.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            idx_d        = idx_q;
            err_d        = err_cnt;
            first_fail_d = first_fail;
            fail_valid_d = fail_valid;
            done_d       = 1'b0;
            pass_d       = 1'b0;
        end

        busy_d = (state_d != IDLE);

        // Stimulus is only presented while a vector is in flight.
        vec_d = '0;
        if ((state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE)) begin
            vec_d = idx_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            vec_q      <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            vec_q      <= vec_d;
            err_cnt    <= err_d;
            first_fail <= first_fail_d;
            fail_valid <= fail_valid_d;
            pass       <= pass_d;
            done       <= done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: one instance with SETTLE_CYC=2
// (with an injectable g-stuck-at-0 fault in its gate model) and one with
// SETTLE_CYC=0 for the vector-sequence check.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // SETTLE_CYC = 2 instance
    logic       start, abort, stuck_g;
    logic       a, b, c, d, e, f, g;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;

    // SETTLE_CYC = 0 instance
    logic       start0, abort0;
    logic       a0, b0, c0, d0, e0, f0, g0;
    logic       busy0, done0, pass0, fail_valid0;
    logic [4:0] err_cnt0;
    logic [3:0] first_fail0;

    gate_sweep_ctrl #(.SETTLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail(first_fail), .fail_valid(fail_valid)
    );

    gate_sweep_ctrl #(.SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
        .first_fail(first_fail0), .fail_valid(fail_valid0)
    );

    // Gate blocks under test
    always_comb begin
        e  = ~(a & b);
        f  = ~(c | d);
        g  = stuck_g ? 1'b0 : (a ^ b ^ c ^ d);
        e0 = ~(a0 & b0);
        f0 = ~(c0 | d0);
        g0 = a0 ^ b0 ^ c0 ^ d0;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int         lat;
        logic       pass;
        logic [4:0] err;
        logic [3:0] ff;
        logic       fv;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] vec_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep on the SETTLE_CYC=2 instance; optional extra start
    // pulse at cycle mid (negative = none).
    task automatic run_sweep(input bit stuck, input int mid);
        exp_t x;
        int   n;
        bit   seen;
        x.lat  = 65;
        x.pass = !stuck;
        x.err  = stuck ? 5'd8 : 5'd0;
        x.ff   = 4'd1;
        x.fv   = stuck;
        exp_q.push_back(x);
        stuck_g = stuck;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            start = (n == mid);
            tick();
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        x = exp_q.pop_front();
        check("done_latency", n, x.lat);
        check("pass", pass, x.pass);
        check("err_cnt", err_cnt, x.err);
        check("fail_valid", fail_valid, x.fv);
        if (x.fv) check("first_fail", first_fail, x.ff);
        check("busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        stuck_g = 1'b0;
    endtask

    initial begin
        int n;
        int dc;
        rst = 1'b0; start = 1'b0; abort = 1'b0; stuck_g = 1'b0;
        start0 = 1'b0; abort0 = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_abcd", {a, b, c, d}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ff", first_fail, 0);
        check("rst_fv", fail_valid, 0);
        check("rst_dut0", {a0, b0, c0, d0, busy0, done0, pass0, err_cnt0, first_fail0, fail_valid0}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Correct gate block, SETTLE_CYC=2
        run_sweep(1'b0, -1);

        // start+abort together in IDLE: abort wins
        dc = done_cnt;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);
        repeat (5) tick();
        check("sa_busy_later", busy, 0);
        check("sa_abcd", {a, b, c, d}, 0);
        check("sa_pass_held", pass, 1);
        check("sa_no_done", done_cnt, dc);

        // Abort at cycle 20 of a faulty sweep; vectors 1 and 2 already failed
        stuck_g = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_abcd", {a, b, c, d}, 0);
        check("ab_pass", pass, 0);
        check("ab_err_held", err_cnt, 2);
        check("ab_ff_held", first_fail, 1);
        check("ab_fv_held", fail_valid, 1);
        dc = done_cnt;
        repeat (80) tick();
        check("ab_no_done", done_cnt, dc);
        check("ab_idle", busy, 0);
        stuck_g = 1'b0;
        run_sweep(1'b0, -1);

        // Extra start mid-sweep is ignored
        run_sweep(1'b0, 30);

        // g stuck at 0: odd-parity vectors fail
        run_sweep(1'b1, -1);
        run_sweep(1'b0, -1);

        // Reset between edges during vector 7
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        check("pre_rst_abcd", {a, b, c, d}, 4'd7);
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_abcd", {a, b, c, d}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_err", {err_cnt, first_fail, fail_valid, done}, 0);
        #3 rst = 1'b0;
        repeat (80) tick();
        check("rst_no_done", done_cnt, dc);
        check("rst_idle", busy, 0);
        run_sweep(1'b0, -1);

        // SETTLE_CYC=0: each vector held exactly 2 cycles, done after 33
        for (int i = 0; i < 32; i++) vec_q.push_back(4'(i / 2));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 100) begin
            if (vec_q.size() > 0) check("s0_vec", {a0, b0, c0, d0}, vec_q.pop_front());
            tick();
            n++;
        end
        check("s0_done_latency", n, 33);
        check("s0_pass", pass0, 1);
        check("s0_err", err_cnt0, 0);
        check("s0_fv", fail_valid0, 0);
        check("s0_idle_abcd", {a0, b0, c0, d0, busy0}, 0);
        tick();
        check("s0_done_one_cycle", done0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
